// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM test requester.
package sdram_test_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    DONE,
    FAIL
  } testState_t;

  function automatic logic [DATA_W-1:0] xorPattern(input logic [DATA_W-1:0] addrLow,
                                                   input logic [DATA_W-1:0] seed);
    return addrLow ^ seed;
  endfunction

endpackage

// File: rtl/sdram_test_pattern_gen.sv
// Test pattern source: address-XOR by default, Galois LFSR when
// SDRAM_TEST_LFSR_PATTERN_EN is defined.
module sdram_test_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 16'hA5C3
) (
  input  logic              activeClock,
  input  logic              reset_n,
  input  logic              reseed,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

`ifdef SDRAM_TEST_LFSR_PATTERN_EN
  // An all-zero seed would lock the LFSR up.
  localparam logic [DATA_W-1:0] LOAD_VALUE = (SEED == '0) ? 16'h0001 : SEED;

  logic [DATA_W-1:0] lfsr;
  logic              unusedAddr;

  always_ff @(posedge activeClock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LOAD_VALUE;
    end else if (reseed) begin
      lfsr <= LOAD_VALUE;
    end else if (step) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
    end
  end

  assign data       = lfsr;
  assign unusedAddr = ^addr;
`else
  logic unusedInputs;

  assign data         = xorPattern(addr[DATA_W-1:0], SEED);
  assign unusedInputs = ^{activeClock, reset_n, reseed, step, addr[ADDR_W-1:DATA_W]};
`endif

endmodule

// File: rtl/sdram_test_requester.sv
// Write/read-back memory test master for the SDRAM controller user interface.
// Pattern mode selected by SDRAM_TEST_LFSR_PATTERN_EN (see sdram_test_pattern_gen).
//
// state   | meaning
// IDLE    | waiting for start
// WR_REQ  | write command raised, waiting for accept
// WR_WAIT | write accepted, waiting for controller not busy
// RD_REQ  | read command raised, waiting for accept
// RD_WAIT | read accepted, waiting for read data
// DONE    | all words checked
// FAIL    | a wait state timed out
module sdram_test_requester
  import sdram_test_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 25'd0,
  parameter int unsigned       NUM_WORDS      = 1024,
  parameter logic [DATA_W-1:0] SEED           = 16'hA5C3,
  parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
  input  logic              activeClock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] req_address,
  output logic [DATA_W-1:0] req_writeData,
  output logic              req_isWriting,
  output logic              req_inputValid,
  input  logic [DATA_W-1:0] ctrl_outputData,
  input  logic              ctrl_outputValid,
  input  logic              ctrl_isBusy,
  input  logic              ctrl_recievedCommand,
  output logic              busy,
  output logic              done,
  output logic              passed,
  output logic              timedOut,
  output logic [DATA_W-1:0] errorCount,
  output logic [ADDR_W-1:0] firstErrorAddress
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  WORDS_LOAD = ADDR_W'(NUM_WORDS - 1);

  testState_t        state, nextState;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wordsLeft;
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0] patternData;
  logic              waiting, lastWord;
  logic              startTest, advance, reseed, mismatch;

  assign waiting  = (state == WR_REQ) || (state == WR_WAIT) ||
                    (state == RD_REQ) || (state == RD_WAIT);
  assign lastWord = (wordsLeft == '0);

  sdram_test_pattern_gen #(.SEED(SEED)) patternGen (
    .activeClock(activeClock),
    .reset_n    (reset_n),
    .reseed     (reseed),
    .step       (advance),
    .addr       (addr),
    .data       (patternData)
  );

  always_comb begin
    nextState = state;
    startTest = 1'b0;
    advance   = 1'b0;
    reseed    = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          startTest = 1'b1;
          reseed    = 1'b1;
          nextState = WR_REQ;
        end
      end
      WR_REQ:  if (ctrl_recievedCommand) nextState = WR_WAIT;
      WR_WAIT: begin
        if (!ctrl_isBusy) begin
          advance = 1'b1;
          if (lastWord) begin
            reseed    = 1'b1;
            nextState = RD_REQ;
          end else begin
            nextState = WR_REQ;
          end
        end
      end
      RD_REQ:  if (ctrl_recievedCommand) nextState = RD_WAIT;
      RD_WAIT: begin
        if (ctrl_outputValid) begin
          advance   = 1'b1;
          mismatch  = (ctrl_outputData != patternData);
          nextState = lastWord ? DONE : RD_REQ;
        end
      end
      default: nextState = IDLE;
    endcase
    // A transition on the terminal cycle still wins over the abort.
    if (waiting && (timer == '0) && (nextState == state)) nextState = FAIL;
  end

  always_ff @(posedge activeClock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      addr              <= '0;
      wordsLeft         <= '0;
      timer             <= '0;
      errorCount        <= '0;
      firstErrorAddress <= '0;
    end else begin
      state <= nextState;
      if (nextState != state) begin
        timer <= TIMER_LOAD;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (startTest) begin
        addr              <= BASE_ADDR;
        wordsLeft         <= WORDS_LOAD;
        errorCount        <= '0;
        firstErrorAddress <= '0;
      end else if (advance) begin
        addr      <= lastWord ? BASE_ADDR : addr + 1'b1;
        wordsLeft <= lastWord ? WORDS_LOAD : wordsLeft - 1'b1;
      end

      if (mismatch) begin
        if (errorCount == '0) firstErrorAddress <= addr;
        if (errorCount != '1) errorCount <= errorCount + 1'b1;
      end
    end
  end

  assign req_address    = addr;
  assign req_isWriting  = (state == WR_REQ);
  assign req_writeData  = req_isWriting ? patternData : '0;
  assign req_inputValid = (state == WR_REQ) || (state == RD_REQ);
  assign busy           = waiting;
  assign done           = (state == DONE) || (state == FAIL);
  assign passed         = (state == DONE) && (errorCount == '0);
  assign timedOut       = (state == FAIL);

endmodule

// File: tb/tb_sdram_test_requester.sv
// Self-checking bench: randomized behavioural SDRAM controller model driving
// two requester instances (base 0 with short timeout, base near top of memory).
`timescale 1ns/1ps
module tb_sdram_test_requester;

`ifdef SDRAM_TEST_LFSR_PATTERN_EN
  localparam logic [15:0] SEED_A  = 16'h0000;
  localparam logic [15:0] FIRST_A = 16'h0001;
`else
  localparam logic [15:0] SEED_A  = 16'hA5C3;
  localparam logic [15:0] FIRST_A = 16'hA5C3;
`endif
  localparam logic [15:0] SEED_B = 16'h5A17;
  localparam int          NW     = 4;
  localparam logic [24:0] BASE_A = 25'd0;
  localparam logic [24:0] BASE_B = 25'h1FFFFFE;

  typedef struct packed {
    logic        wr;
    logic [24:0] addr;
    logic [15:0] data;
  } cmd_t;

  logic clk, rstN, aStart, bStart, sel;
  logic [24:0] aAddr, bAddr, aFirst, bFirst;
  logic [15:0] aWData, bWData, aErr, bErr;
  logic aWr, bWr, aValid, bValid, aBusy, bBusy, aDone, bDone;
  logic aPassed, bPassed, aTimedOut, bTimedOut;

  logic [15:0] ctrlData;
  logic ctrlOutValid, ctrlBusy, ctrlAck, spurAck, spurValid;
  logic ackIn, outValidIn;

  int vectors = 0;
  int miscompares = 0;

  cmd_t cmdQ[$];
  logic [15:0] mem [8];
  int busyLeft, rdLeft, busyLen, rdLat, stallCycles;
  bit stallDone, noAck;
  logic [7:0] corruptMask;
  logic [2:0] rdIdx;

  assign ackIn      = ctrlAck | spurAck;
  assign outValidIn = ctrlOutValid | spurValid;

  logic        mValid, mWr, mDone, mPassed, mBusy, mTimedOut;
  logic [24:0] mAddr, mFirst;
  logic [15:0] mData, mErr;
  assign mValid    = sel ? bValid    : aValid;
  assign mWr       = sel ? bWr       : aWr;
  assign mAddr     = sel ? bAddr     : aAddr;
  assign mData     = sel ? bWData    : aWData;
  assign mDone     = sel ? bDone     : aDone;
  assign mPassed   = sel ? bPassed   : aPassed;
  assign mBusy     = sel ? bBusy     : aBusy;
  assign mTimedOut = sel ? bTimedOut : aTimedOut;
  assign mErr      = sel ? bErr      : aErr;
  assign mFirst    = sel ? bFirst    : aFirst;

  logic [87:0] aAll, bAll;
  assign aAll = {aAddr, aWData, aWr, aValid, aBusy, aDone, aPassed, aTimedOut, aErr, aFirst};
  assign bAll = {bAddr, bWData, bWr, bValid, bBusy, bDone, bPassed, bTimedOut, bErr, bFirst};

  sdram_test_requester #(.BASE_ADDR(BASE_A), .NUM_WORDS(NW), .SEED(SEED_A), .TIMEOUT_CYCLES(64)) dutA (
    .activeClock(clk), .reset_n(rstN), .start(aStart),
    .req_address(aAddr), .req_writeData(aWData), .req_isWriting(aWr), .req_inputValid(aValid),
    .ctrl_outputData(ctrlData), .ctrl_outputValid(outValidIn), .ctrl_isBusy(ctrlBusy),
    .ctrl_recievedCommand(ackIn),
    .busy(aBusy), .done(aDone), .passed(aPassed), .timedOut(aTimedOut),
    .errorCount(aErr), .firstErrorAddress(aFirst)
  );

  sdram_test_requester #(.BASE_ADDR(BASE_B), .NUM_WORDS(NW), .SEED(SEED_B)) dutB (
    .activeClock(clk), .reset_n(rstN), .start(bStart),
    .req_address(bAddr), .req_writeData(bWData), .req_isWriting(bWr), .req_inputValid(bValid),
    .ctrl_outputData(ctrlData), .ctrl_outputValid(outValidIn), .ctrl_isBusy(ctrlBusy),
    .ctrl_recievedCommand(ackIn),
    .busy(bBusy), .done(bDone), .passed(bPassed), .timedOut(bTimedOut),
    .errorCount(bErr), .firstErrorAddress(bFirst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: accept only when idle, ack one cycle later, busy for a
  // random time, read data after a short latency; optional pre-accept stall.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ctrlAck <= 1'b0; ctrlOutValid <= 1'b0; ctrlBusy <= 1'b0; ctrlData <= '0;
      busyLeft <= 0; rdLeft <= 0; stallDone <= 1'b0; busyLen <= 9; rdLat <= 2; rdIdx <= '0;
    end else begin
      ctrlAck <= 1'b0;
      ctrlOutValid <= 1'b0;
      if (rdLeft != 0) begin
        rdLeft <= rdLeft - 1;
        if (rdLeft == 1) begin
          ctrlOutValid <= 1'b1;
          ctrlData <= corruptMask[rdIdx] ? 16'h0000 : mem[rdIdx];
        end
      end
      if (busyLeft != 0) begin
        busyLeft <= busyLeft - 1;
        if (busyLeft == 1) ctrlBusy <= 1'b0;
      end else if (mValid && !noAck) begin
        if (stallCycles != 0 && !stallDone) begin
          busyLeft <= stallCycles; ctrlBusy <= 1'b1; stallDone <= 1'b1;
        end else begin
          ctrlAck <= 1'b1; ctrlBusy <= 1'b1; busyLeft <= busyLen; stallDone <= 1'b0;
          cmdQ.push_back({mWr, mAddr, mData});
          if (mWr) mem[mAddr[2:0]] <= mData;
          else begin rdIdx <= mAddr[2:0]; rdLeft <= rdLat; end
          busyLen <= $urandom_range(9, 3);
          rdLat   <= $urandom_range(3, 2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // A raised command must hold valid/address/data/direction until acknowledged.
  logic [42:0] prevReq;
  bit prevPending = 1'b0;
  always @(negedge clk) begin
    if (!rstN || mTimedOut) begin
      prevPending <= 1'b0;
    end else begin
      if (prevPending) check("req_hold", {mValid, mWr, mAddr, mData}, prevReq);
      prevPending <= mValid && !ackIn;
      prevReq     <= {mValid, mWr, mAddr, mData};
    end
  end

  function automatic logic [15:0] expPattern(input int i, input logic [24:0] a, input logic [15:0] seed);
`ifdef SDRAM_TEST_LFSR_PATTERN_EN
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    if (a[0] === 1'bx) v = 16'hxxxx;
    return v;
`else
    if (i < 0) return 16'h0000;
    return a[15:0] ^ seed;
`endif
  endfunction

  task automatic pulseStart(input bit s);
    @(negedge clk);
    if (s) bStart = 1'b1; else aStart = 1'b1;
    @(negedge clk);
    aStart = 1'b0; bStart = 1'b0;
  endtask

  task automatic runTest(input bit s, input logic [24:0] base, input logic [15:0] seed,
                         input logic [7:0] cmask, input int stall, input string tag);
    int cyc, expErr;
    logic [24:0] a, expFirst;
    cmdQ.delete();
    corruptMask = cmask;
    stallCycles = stall;
    sel = s;
    pulseStart(s);
    cyc = 0;
    while (!mDone && cyc < 3000) begin @(negedge clk); cyc++; end
    check({tag, "_done"}, mDone, 1);
    check({tag, "_cmds"}, cmdQ.size(), 2 * NW);
    expErr = 0;
    expFirst = '0;
    for (int i = 0; i < NW; i++) begin
      a = base + 25'(i);
      if (cmdQ.size() == 2 * NW) begin
        check({tag, "_wr"}, {cmdQ[i].wr, cmdQ[i].addr, cmdQ[i].data}, {1'b1, a, expPattern(i, a, seed)});
        check({tag, "_rd"}, {cmdQ[NW+i].wr, cmdQ[NW+i].addr}, {1'b0, a});
      end
      if (cmask[a[2:0]]) begin
        if (expErr == 0) expFirst = a;
        expErr++;
      end
    end
    check({tag, "_errcnt"}, mErr, expErr);
    check({tag, "_firsterr"}, mFirst, expFirst);
    check({tag, "_passed"}, mPassed, (expErr == 0));
    check({tag, "_flags"}, {mTimedOut, mBusy, mValid}, 3'b000);
  endtask

  initial begin
    int cyc, hi;
    rstN = 1'b0; aStart = 1'b0; bStart = 1'b0; sel = 1'b0;
    noAck = 1'b0; stallCycles = 0; corruptMask = '0; spurAck = 1'b0; spurValid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", aAll, 88'd0);
    check("reset_b", bAll, 88'd0);
    rstN = 1'b1;

    runTest(1'b0, BASE_A, SEED_A, 8'h00, 0, "clean");
    if (cmdQ.size() != 0) check("first_wr_data", cmdQ[0].data, FIRST_A);

    @(negedge clk); spurAck = 1'b1; spurValid = 1'b1;
    @(negedge clk); spurAck = 1'b0; spurValid = 1'b0;
    repeat (2) @(negedge clk);
    check("spurious_ignored", {aDone, aPassed, aBusy, aValid, aErr, 25'(cmdQ.size())}, {4'b1100, 16'd0, 25'(2 * NW)});

    runTest(1'b0, BASE_A, SEED_A, 8'h04, 0, "corrupt2");
    check("corrupt2_first_addr", aFirst, 25'd2);

    runTest(1'b0, BASE_A, SEED_A, 8'h00, 10, "stall");
    for (int r = 0; r < 3; r++)
      runTest(1'b0, BASE_A, SEED_A, 8'($urandom_range(15, 0)), $urandom_range(4, 0), "rand_a");

    noAck = 1'b1;
    cmdQ.delete();
    sel = 1'b0;
    pulseStart(1'b0);
    cyc = 0; hi = 0;
    while (!aDone && cyc < 500) begin
      if (aValid) hi++;
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", hi, 64);
    check("timeout_flags", {aTimedOut, aDone, aValid, aPassed, aBusy}, 5'b11000);
    check("timeout_no_cmds", cmdQ.size(), 0);
    noAck = 1'b0;
    runTest(1'b0, BASE_A, SEED_A, 8'h00, 0, "after_timeout");

    runTest(1'b1, BASE_B, SEED_B, 8'h00, 0, "wrap");
    if (cmdQ.size() == 2 * NW)
      check("wrap_addrs", {cmdQ[1].addr, cmdQ[2].addr, cmdQ[7].addr}, {25'h1FFFFFF, 25'h0, 25'h1});

    cmdQ.delete();
    sel = 1'b1;
    pulseStart(1'b1);
    cyc = 0;
    while (cmdQ.size() < NW + 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("second_read_reached", cmdQ.size(), NW + 2);
    #2 rstN = 1'b0;
    #1;
    check("midreset_b", bAll, 88'd0);
    check("midreset_a", aAll, 88'd0);
    @(negedge clk);
    rstN = 1'b1;
    runTest(1'b1, BASE_B, SEED_B, 8'h00, 0, "rerun");
    runTest(1'b1, BASE_B, SEED_B, 8'h80, 0, "wrap_err");
    runTest(1'b1, BASE_B, SEED_B, 8'($urandom_range(255, 0)), $urandom_range(4, 0), "rand_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
